// File: rtl/shift_add_multiply_accumulate.sv
// ----------------------------------------------------------------------------
// shift_add_multiply_accumulate
//   Sequential unsigned shift-and-add multiply-accumulate:
//     product = multiplicand * multiplier + addend
//   The multiplier is consumed one bit per clock, LSB first. This block is the
//   inverse of the non-restoring divider: divisor, quotient and remainder go in,
//   and the dividend comes out. It also works as a standalone multiplier.
//
// Ports
//   clk           in   1        rising-edge clock
//   rst           in   1        synchronous active-high reset, highest priority
//   start         in   1        job request, honoured only in IDLE
//   multiplicand  in   WIDTH    unsigned operand (divisor in round-trip use)
//   multiplier    in   WIDTH    unsigned operand (quotient in round-trip use)
//   addend        in   WIDTH    unsigned addend (remainder in round-trip use)
//   busy          out  1        high while stepping through multiplier bits
//   done          out  1        one-cycle pulse when product is updated
//   product       out  2*WIDTH  registered result, held until the next done
// ----------------------------------------------------------------------------
module shift_add_multiply_accumulate #(
   parameter int WIDTH = 8
) (
   input  logic                 clk,
   input  logic                 rst,
   input  logic                 start,
   input  logic [WIDTH-1:0]     multiplicand,
   input  logic [WIDTH-1:0]     multiplier,
   input  logic [WIDTH-1:0]     addend,
   output logic                 busy,
   output logic                 done,
   output logic [2*WIDTH-1:0]   product
);

   localparam int PW = 2 * WIDTH;
   localparam int CW = $clog2(WIDTH + 1);
   localparam logic [CW-1:0] LAST_STEP = CW'(WIDTH - 1);

   typedef enum logic [1:0] {
      S_IDLE = 2'b00,
      S_STEP = 2'b01,
      S_DONE = 2'b10,
      S_BAD  = 2'b11
   } state_e;

   state_e            state_q, state_d;
   logic [PW-1:0]     acc_q, acc_d;
   logic [PW-1:0]     mcand_q, mcand_d;
   logic [WIDTH-1:0]  mplier_q, mplier_d;
   logic [CW-1:0]     count_q, count_d;
   logic [PW-1:0]     product_q, product_d;
   logic [PW-1:0]     sum;

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q   <= S_IDLE;
         acc_q     <= '0;
         mcand_q   <= '0;
         mplier_q  <= '0;
         count_q   <= '0;
         product_q <= '0;
      end else begin
         state_q   <= state_d;
         acc_q     <= acc_d;
         mcand_q   <= mcand_d;
         mplier_q  <= mplier_d;
         count_q   <= count_d;
         product_q <= product_d;
      end
   end

   // Accumulator after this step's conditional add; the final step's value
   // goes straight to product so the add of the top bit is not lost.
   assign sum = mplier_q[0] ? (acc_q + mcand_q) : acc_q;

   always_comb begin
      state_d   = state_q;
      acc_d     = acc_q;
      mcand_d   = mcand_q;
      mplier_d  = mplier_q;
      count_d   = count_q;
      product_d = product_q;
      case (state_q)
         S_IDLE: begin
            if (start) begin
               acc_d    = {{WIDTH{1'b0}}, addend};
               mcand_d  = {{WIDTH{1'b0}}, multiplicand};
               mplier_d = multiplier;
               count_d  = '0;
               state_d  = S_STEP;
            end
         end
         S_STEP: begin
            acc_d    = sum;
            mcand_d  = mcand_q << 1;
            mplier_d = mplier_q >> 1;
            count_d  = count_q + CW'(1);
            if (count_q == LAST_STEP) begin
               product_d = sum;
               state_d   = S_DONE;
            end
         end
         S_DONE: begin
            // start arriving here is dropped, not queued
            state_d = S_IDLE;
         end
         default: begin
            // Illegal code: recover to IDLE with everything at reset values
            state_d   = S_IDLE;
            acc_d     = '0;
            mcand_d   = '0;
            mplier_d  = '0;
            count_d   = '0;
            product_d = '0;
         end
      endcase
   end

   assign busy    = (state_q == S_STEP);
   assign done    = (state_q == S_DONE);
   assign product = product_q;

endmodule

// File: tb/tb_shift_add_multiply_accumulate.sv
module tb_shift_add_multiply_accumulate;

   localparam int W  = 8;
   localparam int PW = 2 * W;

   logic          clk = 1'b0;
   logic          rst;
   logic          start;
   logic [W-1:0]  multiplicand, multiplier, addend;
   logic          busy, done;
   logic [PW-1:0] product;

   int total = 0;
   int bad   = 0;
   int done_cnt = 0;
   logic [PW-1:0] exp_q[$];

   shift_add_multiply_accumulate #(.WIDTH(W)) dut (
      .clk          (clk),
      .rst          (rst),
      .start        (start),
      .multiplicand (multiplicand),
      .multiplier   (multiplier),
      .addend       (addend),
      .busy         (busy),
      .done         (done),
      .product      (product)
   );

   always #5 clk = ~clk;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   // Reference: plain arithmetic on the operands
   function automatic logic [PW-1:0] ref_mac(input int a, input int b, input int c);
      return PW'(a * b + c);
   endfunction

   // Monitor: every done pulse must match the oldest outstanding expectation
   always @(negedge clk) begin
      if (!rst && done) begin
         done_cnt++;
         if (exp_q.size() == 0) begin
            total++;
            bad++;
            $display("FAIL spurious_done: got product %0h expected no done", product);
         end else begin
            chk("product", 32'(product), 32'(exp_q.pop_front()));
         end
      end
   end

   // Watchdog
   initial begin
      #2000000;
      $display("FAIL watchdog: got timeout expected test end");
      $fatal(1, "timeout");
   end

   // Issue one job from a negedge; checks busy/done timing and held product.
   task automatic run_job(input int a, input int b, input int c);
      logic [PW-1:0] e;
      e = ref_mac(a, b, c);
      @(negedge clk);
      start = 1'b1;
      multiplicand = W'(a); multiplier = W'(b); addend = W'(c);
      exp_q.push_back(e);
      @(negedge clk);                 // cycle 1
      start = 1'b0;
      for (int i = 1; i <= W; i++) begin
         chk("busy_step", 32'(busy), 32'd1);
         chk("done_step", 32'(done), 32'd0);
         @(negedge clk);
      end
      chk("busy_done", 32'(busy), 32'd0);   // cycle W+1
      chk("done_pulse", 32'(done), 32'd1);
      @(negedge clk);                       // cycle W+2
      chk("done_low", 32'(done), 32'd0);
      chk("product_held", 32'(product), 32'(e));
   endtask

   initial begin
      int a, b, c, dvd, dvs, d0;
      rst = 1'b1; start = 1'b1;
      multiplicand = 8'd3; multiplier = 8'd5; addend = 8'd1;
      // Reset with start held high: nothing may start
      for (int i = 0; i < 3; i++) begin
         @(negedge clk);
         chk("rst_busy", 32'(busy), 32'd0);
         chk("rst_done", 32'(done), 32'd0);
         chk("rst_product", 32'(product), 32'd0);
      end
      rst = 1'b0; start = 1'b0;
      @(negedge clk);
      chk("idle_busy", 32'(busy), 32'd0);

      // Directed cases
      run_job(13, 11, 5);
      chk("basic", 32'(product), 32'h0094);
      run_job(255, 255, 255);
      chk("max", 32'(product), 32'hFF00);
      run_job(0, 0, 0);
      run_job(8'h37, 0, 8'h2A);
      chk("zero_mplier", 32'(product), 32'h002A);
      run_job(7, 28, 4);
      chk("roundtrip_200", 32'(product), 32'd200);

      // Protocol: re-pulse start in cycles 3 and 9, change operands in cycle 1
      @(negedge clk);
      d0 = done_cnt;
      start = 1'b1; multiplicand = 8'd21; multiplier = 8'd19; addend = 8'd6;
      exp_q.push_back(ref_mac(21, 19, 6));
      for (int cyc = 1; cyc <= 11; cyc++) begin
         @(negedge clk);
         start = (cyc == 3 || cyc == 9);
         if (cyc == 1) begin
            multiplicand = 8'hFF; multiplier = 8'hAA; addend = 8'h55;
         end
         if (cyc == 10 || cyc == 11) chk("no_restart", 32'(busy), 32'd0);
      end
      start = 1'b0;
      chk("single_done", 32'(done_cnt - d0), 32'd1);
      chk("proto_product", 32'(product), 32'(ref_mac(21, 19, 6)));

      // Abort: rst in cycle 4 of a job
      @(negedge clk);
      d0 = done_cnt;
      start = 1'b1; multiplicand = 8'd100; multiplier = 8'd77; addend = 8'd3;
      for (int cyc = 1; cyc <= 4; cyc++) begin
         @(negedge clk);
         start = 1'b0;
      end
      rst = 1'b1;
      @(negedge clk);
      rst = 1'b0;
      chk("abort_busy", 32'(busy), 32'd0);
      chk("abort_done", 32'(done), 32'd0);
      chk("abort_product", 32'(product), 32'd0);
      repeat (12) @(negedge clk);
      chk("abort_no_done", 32'(done_cnt - d0), 32'd0);
      run_job(9, 9, 0);
      chk("after_abort", 32'(product), 32'h0051);

      // Random multiply-accumulate
      for (int n = 0; n < 200; n++) begin
         a = $urandom_range(0, 255); b = $urandom_range(0, 255); c = $urandom_range(0, 255);
         run_job(a, b, c);
      end
      // Random divider round trips: divisor, quotient, remainder -> dividend
      for (int n = 0; n < 200; n++) begin
         dvd = $urandom_range(0, 255); dvs = $urandom_range(1, 255);
         run_job(dvs, dvd / dvs, dvd % dvs);
         chk("roundtrip", 32'(product), 32'(dvd));
      end

      repeat (3) @(negedge clk);
      chk("queue_empty", 32'(exp_q.size()), 32'd0);
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
